// File: rtl/demoscene_pkg.sv
// Shared constants and types for the demoscene SPI configuration slave.
package demoscene_pkg;

    // Command byte layout: bit 7 selects write, bits 6:0 carry the start address
    localparam int CMD_W_BIT = 7;
    localparam int ADDR_W    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_t;

    // Register map as seen by the demoscene datapath
    localparam logic [ADDR_W-1:0] REG_EFFECT  = 7'd0;
    localparam logic [ADDR_W-1:0] REG_PALETTE = 7'd1;
    localparam logic [ADDR_W-1:0] REG_SCROLL  = 7'd2;
    localparam logic [ADDR_W-1:0] REG_AUDIO   = 7'd3;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, with single-cycle
// rise/fall pulses taken from the second and third stages.
module spi_sync_edge #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] r_sync;

    // Shift the pin through the synchroniser; reset to the pin's idle level so no edge is seen after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {3{IDLE_LVL}};
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_rise =  r_sync[1] & ~r_sync[2];
    assign o_fall = ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/spi_config_ctrl.sv
// SPI mode-0 slave with a flat configuration register file. Byte 0 of a frame
// is the command (W bit + start address); following bytes write or read
// consecutive registers with a 7-bit wrapping address.
module spi_config_ctrl
    import demoscene_pkg::*;
#(
    parameter int                    NUM_REGS  = 8,
    parameter logic [NUM_REGS*8-1:0] REG_RESET = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    ssel,
    input  logic                    mosi,
    output logic                    miso,
    output logic [NUM_REGS*8-1:0]   cfg_regs,
    output logic                    cfg_wr_stb,
    output logic [ADDR_W-1:0]       cfg_wr_addr
);

    spi_state_t            r_state;
    spi_state_t            w_state_nxt;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_ssel_rise;
    logic                  w_ssel_fall;
    logic                  r_mosi_meta;
    logic                  r_mosi_sync;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift_in;
    logic [7:0]            r_miso_sr;
    logic                  r_w;
    logic [ADDR_W-1:0]     r_addr;
    logic [NUM_REGS*8-1:0] r_cfg_regs;
    logic                  r_stb;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic                  w_active;
    logic                  w_bit_rise;
    logic                  w_bit_fall;
    logic                  w_byte_done;
    logic [7:0]            w_byte;
    logic                  w_in_range;

    // Register lookup; addresses beyond the implemented range read as zero
    function automatic logic [7:0] read_reg(input logic [ADDR_W-1:0] a,
                                            input logic [NUM_REGS*8-1:0] regs);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_W'(i)) v = regs[i*8 +: 8];
        end
        return v;
    endfunction

    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.IDLE_LVL(1'b1)) u_ssel_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(ssel),
        .o_rise (w_ssel_rise),
        .o_fall (w_ssel_fall)
    );

    // mosi only needs a level synchroniser; it is sampled on detected sclk rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // A deselect in the same cycle as an sclk edge wins: the edge is dropped
    assign w_active    = (r_state != IDLE) && !w_ssel_rise;
    assign w_bit_rise  = w_active && w_sclk_rise;
    assign w_bit_fall  = w_active && w_sclk_fall;
    assign w_byte_done = w_bit_rise && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift_in[6:0], r_mosi_sync};
    assign w_in_range  = (32'(r_addr) < NUM_REGS);

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Frame sequencing: command byte first, then any number of data bytes until deselect
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_ssel_fall) w_state_nxt = CMD;
            CMD:     if (w_byte_done) w_state_nxt = DATA;
            DATA:    w_state_nxt = DATA;
            default: w_state_nxt = IDLE;
        endcase
        if (w_ssel_rise) w_state_nxt = IDLE;
    end

    // Bit capture, register writes and read-data loading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift_in <= 8'h00;
            r_miso_sr  <= 8'h00;
            r_w        <= 1'b0;
            r_addr     <= '0;
            r_cfg_regs <= REG_RESET;
            r_stb      <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_stb <= 1'b0;
            if (!w_active) begin
                // Outside a frame (or on deselect) any partial byte is discarded
                r_bit_cnt <= 3'd0;
                r_miso_sr <= 8'h00;
            end else begin
                if (w_bit_rise) begin
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_shift_in <= w_byte;
                end
                // The fall right after a byte boundary keeps the freshly loaded MSB for the next rise
                if (w_bit_fall && (r_state == DATA) && (r_bit_cnt != 3'd0)) begin
                    r_miso_sr <= {r_miso_sr[6:0], 1'b0};
                end
                if (w_byte_done) begin
                    if (r_state == CMD) begin
                        r_w       <= w_byte[CMD_W_BIT];
                        r_addr    <= w_byte[ADDR_W-1:0];
                        r_miso_sr <= read_reg(w_byte[ADDR_W-1:0], r_cfg_regs);
                    end else begin
                        if (r_w) begin
                            if (w_in_range) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (r_addr == ADDR_W'(i)) r_cfg_regs[i*8 +: 8] <= w_byte;
                                end
                                r_stb     <= 1'b1;
                                r_wr_addr <= r_addr;
                            end
                        end else begin
                            r_miso_sr <= read_reg(r_addr + 1'b1, r_cfg_regs);
                        end
                        r_addr <= r_addr + 1'b1;
                    end
                end
            end
        end
    end

    assign miso        = (r_state != IDLE) && !r_w && r_miso_sr[7];
    assign cfg_regs    = r_cfg_regs;
    assign cfg_wr_stb  = r_stb;
    assign cfg_wr_addr = r_wr_addr;

endmodule

// File: tb/tb_spi_config_ctrl.sv
// Self-checking bench for spi_config_ctrl: directed frame table, hand-written
// abort/reset sequences and randomized frames against a byte-level model.
module tb_spi_config_ctrl;

    localparam int              NR      = 8;
    localparam logic [NR*8-1:0] RST_VAL = 64'h8877_6655_4433_2211;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          ssel = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [NR*8-1:0] cfg_regs;
    logic          cfg_wr_stb;
    logic [6:0]    cfg_wr_addr;

    spi_config_ctrl #(.NUM_REGS(NR), .REG_RESET(RST_VAL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ssel       (ssel),
        .mosi       (mosi),
        .miso       (miso),
        .cfg_regs   (cfg_regs),
        .cfg_wr_stb (cfg_wr_stb),
        .cfg_wr_addr(cfg_wr_addr)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Strobe monitor: one queue entry per clock the strobe is high
    logic [6:0] stb_addr_q[$];
    always @(negedge clk) begin
        if (rst_n && cfg_wr_stb) stb_addr_q.push_back(cfg_wr_addr);
    end

    // Reference model: register bytes, last write address, expected strobe addresses
    logic [7:0] m_regs[NR];
    logic [6:0] m_wr_addr;
    logic [6:0] m_stb_q[$];

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [31:0] data;
        int          exp_stb;
        logic [6:0]  exp_wr;
        logic [31:0] exp_rx;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = RST_VAL[i*8 +: 8];
        m_wr_addr = 7'd0;
    endtask

    function automatic logic [NR*8-1:0] model_flat();
        logic [NR*8-1:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = m_regs[i];
        return f;
    endfunction

    // Frame semantics: data byte k targets (addr+k) mod 128
    task automatic model_frame(input logic [7:0] cmd, input int n, input logic [31:0] data,
                               output logic [31:0] rx);
        int a;
        rx = '0;
        for (int k = 0; k < n; k++) begin
            a = (int'(cmd[6:0]) + k) % 128;
            if (cmd[7]) begin
                if (a < NR) begin
                    m_regs[a] = data[31-8*k -: 8];
                    m_wr_addr = 7'(a);
                    m_stb_q.push_back(7'(a));
                end
            end else begin
                rx[31-8*k -: 8] = (a < NR) ? m_regs[a] : 8'h00;
            end
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            mosi = tx[7-b];
            half();
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int n, input logic [31:0] data,
                             output logic [31:0] rx);
        logic [7:0] r;
        rx = '0;
        ssel = 1'b0;
        half();
        spi_byte(cmd, 8, r);
        for (int k = 0; k < n; k++) begin
            spi_byte(data[31-8*k -: 8], 8, r);
            rx[31-8*k -: 8] = r;
        end
        half();
        ssel = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input int n,
                             input logic [31:0] data,
                             output logic [31:0] rx_dut, output logic [31:0] rx_mod);
        stb_addr_q.delete();
        m_stb_q.delete();
        model_frame(cmd, n, data, rx_mod);
        spi_frame(cmd, n, data, rx_dut);
        check({tag, " regs"}, cfg_regs, model_flat());
        check({tag, " stb_cycles"}, stb_addr_q.size(), m_stb_q.size());
        for (int i = 0; i < m_stb_q.size() && i < stb_addr_q.size(); i++)
            check({tag, " stb_addr"}, stb_addr_q[i], m_stb_q[i]);
        check({tag, " miso_after_ssel"}, miso, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx_d, rx_m;
        logic [7:0]  rb;
        logic [7:0]  cmd;
        int          n;
        logic [31:0] data;

        tbl[0] = '{8'h82, 1, 32'h5A00_0000, 1, 7'd2, 32'h0000_0000};
        tbl[1] = '{8'h86, 3, 32'h1122_3300, 2, 7'd7, 32'h0000_0000};
        tbl[2] = '{8'h81, 1, 32'hA500_0000, 1, 7'd1, 32'h0000_0000};
        tbl[3] = '{8'h01, 1, 32'h0000_0000, 0, 7'd1, 32'hA500_0000};
        tbl[4] = '{8'h7F, 1, 32'hFF00_0000, 0, 7'd1, 32'h0000_0000};
        tbl[5] = '{8'h06, 3, 32'h0000_0000, 0, 7'd1, 32'h1122_0000};
        tbl[6] = '{8'h7E, 3, 32'h0000_0000, 0, 7'd1, 32'h0000_1100};
        tbl[7] = '{8'h80, 0, 32'h0000_0000, 0, 7'd1, 32'h0000_0000};
        tbl[8] = '{8'hFF, 2, 32'h9942_0000, 1, 7'd0, 32'h0000_0000};
        tbl[9] = '{8'h02, 2, 32'h0000_0000, 0, 7'd0, 32'h5A44_0000};

        model_reset();

        // Reset state, during and after reset
        repeat (3) @(negedge clk);
        check("rst regs", cfg_regs, RST_VAL);
        check("rst miso", miso, 1'b0);
        check("rst stb", cfg_wr_stb, 1'b0);
        check("rst wr_addr", cfg_wr_addr, 7'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post-rst regs", cfg_regs, RST_VAL);
        check("post-rst miso", miso, 1'b0);

        // Directed frame table
        for (int v = 0; v < 10; v++) begin
            run_frame($sformatf("tbl%0d", v), tbl[v].cmd, tbl[v].n, tbl[v].data, rx_d, rx_m);
            check($sformatf("tbl%0d rx", v), rx_d, tbl[v].exp_rx);
            check($sformatf("tbl%0d stb_count", v), stb_addr_q.size(), tbl[v].exp_stb);
            check($sformatf("tbl%0d wr_addr", v), cfg_wr_addr, tbl[v].exp_wr);
        end
        check("reg2 written", cfg_regs[23:16], 8'h5A);

        // Aborted frame: command plus 5 bits, then deselect
        stb_addr_q.delete();
        ssel = 1'b0;
        half();
        spi_byte(8'h83, 8, rb);
        spi_byte(8'hFF, 5, rb);
        half();
        ssel = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        check("abort regs", cfg_regs, model_flat());
        check("abort stb", stb_addr_q.size(), 0);
        run_frame("after-abort", 8'h83, 1, 32'h7E00_0000, rx_d, rx_m);
        check("after-abort reg3", cfg_regs[31:24], 8'h7E);

        // Reset in the middle of a write burst
        run_frame("pre-rst", 8'h80, 1, 32'h4400_0000, rx_d, rx_m);
        check("pre-rst reg0", cfg_regs[7:0], 8'h44);
        ssel = 1'b0;
        half();
        spi_byte(8'h80, 8, rb);
        spi_byte(8'h44, 8, rb);
        half();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst regs", cfg_regs, RST_VAL);
        check("midrst miso", miso, 1'b0);
        check("midrst stb", cfg_wr_stb, 1'b0);
        check("midrst wr_addr", cfg_wr_addr, 7'd0);
        ssel = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        run_frame("post-midrst", 8'h80, 1, 32'h3C00_0000, rx_d, rx_m);
        check("post-midrst reg0", cfg_regs[7:0], 8'h3C);
        check("post-midrst stb", stb_addr_q.size(), 1);

        // Randomized frames against the model
        for (int f = 0; f < 30; f++) begin
            cmd[7]   = 1'($urandom_range(0, 1));
            cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(120, 127))
                                                   : 7'($urandom_range(0, 9));
            n    = int'($urandom_range(0, 4));
            data = $urandom;
            run_frame($sformatf("rnd%0d", f), cmd, n, data, rx_d, rx_m);
            check($sformatf("rnd%0d rx", f), rx_d, rx_m);
            check($sformatf("rnd%0d wr_addr", f), cfg_wr_addr, m_wr_addr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
